// File: rtl/wb_fuzz_pkg.sv
// Shared definitions for the Wishbone fuzz responder.
//   resp_state_t  : responder FSM states
//   STATUS_*      : bit positions of the fields in the STATUS register (reg 0)
//   merge_bytes() : byte-lane merge of write data over an old register value
package wb_fuzz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } resp_state_t;

  localparam int STATUS_TXN_LSB = 0;   // txn_count occupies [15:0]
  localparam int STATUS_INT_BIT = 16;  // int_ flag
  localparam int STATUS_ERR_LSB = 24;  // err_count occupies [31:24]

  // Byte lane n of sel selects new_val[8n+7:8n]; other lanes keep old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_fuzz_regfile.sv
// Read/write register bank for regs 1..NUM_REGS-1 of the fuzz responder.
// Index 0 (STATUS) is not stored here; a read of index 0 returns 0 and a
// write to index 0 is ignored.
//   clk, rst_n : clock, async active-low reset (all registers reset to 0)
//   we         : write strobe for one cycle
//   widx       : write register index
//   wdata/sel  : write data and byte-lane enables
//   ridx       : combinational read index
//   rdata      : combinational read data
module wb_fuzz_regfile
  import wb_fuzz_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    sel,
  input  logic [IW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx == IW'(i)) regs[i] <= merge_bytes(regs[i], wdata, sel);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx == IW'(i)) rdata = regs[i];
    end
  end

endmodule

// File: rtl/wb_fuzz_responder.sv
// Wishbone classic responder used as a deterministic fuzzing target.
// Each request is captured in IDLE, held for WAIT_CYCLES wait states and
// answered with a single-cycle wb_ack or wb_err. Errors set a sticky
// interrupt and bump a saturating error counter; acks bump a saturating
// transaction counter. Writing STATUS (reg 0) clears both counters and int_.
//   clk, rst_n         : clock, async active-low reset
//   wb_addr/wb_data    : byte address, write data
//   wb_sel             : byte-lane enables
//   wb_stb/wb_cyc/wb_we: strobe, cycle, write enable
//   wb_data_o          : read data, valid with wb_ack, held until next response
//   wb_ack/wb_err      : one-cycle response pulses
//   int_               : sticky error interrupt
//   txn_count/err_count: saturating ack / err counters
module wb_fuzz_responder
  import wb_fuzz_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  input  logic [3:0]  wb_sel,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic        wb_we,
  output logic [31:0] wb_data_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        int_,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  localparam int IW = $clog2(NUM_REGS);

  resp_state_t state, state_d;
  logic [7:0]  cnt, cnt_d;

  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_sel;
  logic        cap_we;

  logic        req;
  logic [31:0] eff_addr, eff_data;
  logic [3:0]  eff_sel;
  logic        eff_we;
  logic [31:0] offset;
  logic [29:0] word;
  logic        dec_err;
  logic [IW-1:0] idx;
  logic        fire;
  logic        rf_we;
  logic [31:0] rf_rdata;
  logic [31:0] status_val;
  logic [31:0] read_val;

  assign req = wb_cyc & wb_stb;

  // With zero wait states the response is produced on the same edge that
  // would capture the request, so decode works on the live bus in IDLE and
  // on the captured copy otherwise.
  assign eff_addr = (state == IDLE) ? wb_addr : cap_addr;
  assign eff_data = (state == IDLE) ? wb_data : cap_data;
  assign eff_sel  = (state == IDLE) ? wb_sel  : cap_sel;
  assign eff_we   = (state == IDLE) ? wb_we   : cap_we;

  assign offset  = eff_addr - ADDR_BASE;
  assign word    = offset[31:2];
  assign dec_err = (offset[1:0] != 2'b00) || ({2'b00, word} >= 32'(NUM_REGS));
  assign idx     = word[IW-1:0];

  // Entering RESPOND is the edge that commits the response.
  assign fire  = (state_d == RESPOND);
  assign rf_we = fire && eff_we && !dec_err && (idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 8'(WAIT_CYCLES);
          end else begin
            state_d = RESPOND;
          end
        end
      end
      WAIT: begin
        if (!req)            state_d = IDLE;
        else if (cnt == 8'd1) state_d = RESPOND;
        else                 cnt_d   = cnt - 8'd1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_val = '0;
    status_val[STATUS_TXN_LSB +: 16] = txn_count;
    status_val[STATUS_INT_BIT]       = int_;
    status_val[STATUS_ERR_LSB +: 8]  = err_count;
  end

  assign read_val = (idx == '0) ? status_val : rf_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_sel   <= '0;
      cap_we    <= 1'b0;
      wb_data_o <= '0;
      wb_ack    <= 1'b0;
      wb_err    <= 1'b0;
      int_      <= 1'b0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (state == IDLE && req) begin
        cap_addr <= wb_addr;
        cap_data <= wb_data;
        cap_sel  <= wb_sel;
        cap_we   <= wb_we;
      end
      if (fire) begin
        if (dec_err) begin
          wb_err    <= 1'b1;
          wb_data_o <= '0;
          int_      <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          wb_ack    <= 1'b1;
          wb_data_o <= eff_we ? 32'h0 : read_val;
          if (eff_we && idx == '0) begin
            // STATUS write: clears everything, its own ack is not counted.
            int_      <= 1'b0;
            txn_count <= '0;
            err_count <= '0;
          end else if (txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
          end
        end
      end
    end
  end

  wb_fuzz_regfile #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .widx  (idx),
    .wdata (eff_data),
    .sel   (eff_sel),
    .ridx  (idx),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_wb_fuzz_responder.sv
// Self-checking bench for wb_fuzz_responder with a behavioural reference
// model (register array plus counters) updated per transaction.
module tb_wb_fuzz_responder;

  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_addr = '0, wb_data = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_data_o;
  logic        wb_ack, wb_err, int_;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [0:NREGS-1];
  logic [15:0] m_txn;
  logic [7:0]  m_err;
  logic        m_int;

  always #5 clk = ~clk;

  wb_fuzz_responder #(
    .NUM_REGS    (NREGS),
    .ADDR_BASE   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_sel    (wb_sel),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_we     (wb_we),
    .wb_data_o (wb_data_o),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .int_      (int_),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_txn = '0;
    m_err = '0;
    m_int = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".txn"}, {16'h0, txn_count}, {16'h0, m_txn});
    check({tag, ".errc"}, {24'h0, err_count}, {24'h0, m_err});
    check({tag, ".int"}, {31'h0, int_}, {31'h0, m_int});
  endtask

  // One full bus transaction, checked against the model; returns read data.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic we, output logic [31:0] rd);
    logic [31:0] off, exp_rd, v;
    logic        bad, got;
    int          idx, n;
    off = a - BASE;
    bad = (off[1:0] != 2'b00) || ((off >> 2) >= 32'(NREGS));
    idx = int'(off >> 2);
    if (bad)           exp_rd = 32'h0;
    else if (idx == 0) exp_rd = {m_err, 7'b0, m_int, m_txn};
    else               exp_rd = m_regs[idx];

    wb_addr = a; wb_data = d; wb_sel = s; wb_we = we;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (wb_ack || wb_err) got = 1'b1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rd = wb_data_o;

    check({tag, ".latency"}, 32'(n), 32'(WAITC + 1));
    check({tag, ".ack"}, {31'h0, wb_ack}, {31'h0, !bad});
    check({tag, ".err"}, {31'h0, wb_err}, {31'h0, bad});
    if (bad || !we) check({tag, ".rdata"}, wb_data_o, exp_rd);

    if (bad) begin
      m_int = 1'b1;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (we && idx == 0) begin
      m_txn = '0; m_err = '0; m_int = 1'b0;
    end else begin
      if (we) begin
        v = m_regs[idx];
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        m_regs[idx] = v;
      end
      if (m_txn != 16'hFFFF) m_txn = m_txn + 16'd1;
    end
    check_counters(tag);

    @(posedge clk); #1;
    check({tag, ".pulse"}, {30'h0, wb_ack, wb_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        seen;
    int          r;

    model_reset();
    #12;
    check("rst.data_o", wb_data_o, 32'h0);
    check("rst.ack_err", {30'h0, wb_ack, wb_err}, 32'h0);
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back
    txn("w4", 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1, rd);
    txn("r4", 32'h4, 32'h0, 4'hF, 1'b0, rd);
    check("r4.const", rd, 32'hDEAD_BEEF);
    check("r4.txn2", {16'h0, txn_count}, 32'd2);

    // Partial lane write over zero
    txn("w8", 32'h8, 32'h1122_3344, 4'b0101, 1'b1, rd);
    txn("r8", 32'h8, 32'h0, 4'hF, 1'b0, rd);
    check("r8.const", rd, 32'h0022_0044);

    // Misaligned and out-of-range accesses
    txn("mis", 32'h41, 32'h0, 4'hF, 1'b0, rd);
    txn("oor", 32'h40, 32'h1234, 4'hF, 1'b1, rd);
    check("errs.errc2", {24'h0, err_count}, 32'd2);
    check("errs.int1", {31'h0, int_}, 32'd1);

    // sel=0 write is acked with no change
    txn("w8z", 32'h8, 32'hFFFF_FFFF, 4'h0, 1'b1, rd);
    txn("r8z", 32'h8, 32'h0, 4'hF, 1'b0, rd);
    check("r8z.const", rd, 32'h0022_0044);

    // STATUS readback with counters, then clear
    txn("rst0", 32'h0, 32'h0, 4'hF, 1'b0, rd);
    check("rst0.const", rd, {8'd2, 7'b0, 1'b1, 16'd6});
    txn("w0", 32'h0, 32'hABCD_0123, 4'h0, 1'b1, rd);
    check("w0.int0", {31'h0, int_}, 32'd0);
    check("w0.txn0", {16'h0, txn_count}, 32'd0);
    txn("r0", 32'h0, 32'h0, 4'hF, 1'b0, rd);
    check("r0.const", rd, 32'h0);
    check("r0.txn1", {16'h0, txn_count}, 32'd1);

    // Abort: drop cyc one cycle into WAIT
    wb_addr = 32'hC; wb_data = 32'h5555_AAAA; wb_sel = 4'hF; wb_we = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) seen = 1'b1;
    end
    wb_stb = 1'b0;
    check("abort.noresp", {31'h0, seen}, 32'h0);
    check_counters("abort");
    txn("abort.rc", 32'hC, 32'h0, 4'hF, 1'b0, rd);
    check("abort.reg3", rd, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'($urandom_range(1, NREGS - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, NREGS - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(NREGS, 1000)) << 2;
      else             a = 32'h0;
      txn("rnd", a, $urandom, 4'($urandom_range(0, 15)),
          (r == 9) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)), rd);
    end

    // Error counter saturation
    for (int k = 0; k < 260; k++) txn("sat", 32'h80 + 32'(k % 4), 32'h0, 4'hF, 1'b0, rd);
    check("sat.errcFF", {24'h0, err_count}, 32'hFF);

    // Async reset in the middle of a write's wait phase
    txn("pre", 32'h10, 32'h1, 4'hF, 1'b0, rd);
    wb_addr = 32'h14; wb_data = 32'hCAFE_F00D; wb_sel = 4'hF; wb_we = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.ack_err", {30'h0, wb_ack, wb_err}, 32'h0);
    check("arst.data_o", wb_data_o, 32'h0);
    check_counters("arst");
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    txn("post", 32'h14, 32'h0, 4'hF, 1'b0, rd);
    check("post.reg5", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
